tqvp_pwm_fade_ctrl: RTL and testbench

TQVP_PWM_FADE_CTRL -- requirements
Module: tqvp_pwm_fade_ctrl

---
 rtl/pwm_fade_pkg.sv | 45 ++++
 rtl/pwm_fade_tick.sv | 39 +++
 rtl/tqvp_pwm_fade_ctrl.sv | 146 ++++++++++++++
 tb/tb_tqvp_pwm_fade_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_fade_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_fade_pkg
// Brief    : Shared register map, CTRL bit positions, FSM encoding and
//            duty-stepping helpers for the PWM fade controller.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_fade_pkg;

    localparam logic [3:0] c_ADDR_TARGET = 4'h0;
    localparam logic [3:0] c_ADDR_STEP   = 4'h1;
    localparam logic [3:0] c_ADDR_RATE   = 4'h2;
    localparam logic [3:0] c_ADDR_CTRL   = 4'h3;
    localparam logic [3:0] c_ADDR_STATUS = 4'h4;
    localparam logic [3:0] c_ADDR_DUTY   = 4'h5;

    localparam int c_CTRL_EN      = 0;
    localparam int c_CTRL_BREATHE = 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RAMP = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;

    function automatic logic [7:0] f_at_least_one(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

    // One step of size 'step' from 'duty' toward 'goal', clamped so it never passes the goal.
    function automatic logic [7:0] f_step_toward(input logic [7:0] duty,
                                                 input logic [7:0] step,
                                                 input logic [7:0] goal);
        logic [8:0] sum;
        logic [8:0] diff;
        sum  = {1'b0, duty} + {1'b0, step};
        diff = {1'b0, duty} - {1'b0, step};
        if (duty < goal)
            return (sum >= {1'b0, goal}) ? goal : sum[7:0];
        else if (duty > goal)
            return (diff[8] || (diff[7:0] <= goal)) ? goal : diff[7:0];
        else
            return goal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_fade_tick.sv
`default_nettype none
// ============================================================================
// Module   : pwm_fade_tick
// Brief    : Rate prescaler; counts PWM periods and flags when a step is due.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_fade_tick
    import pwm_fade_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_enable,
    input  logic       i_clear,
    input  logic       i_period_start,
    input  logic [7:0] i_rate,
    output logic       o_step_due
);

    logic [7:0] r_count;
    logic [7:0] w_limit;
    logic       w_match;

    assign w_limit = f_at_least_one(i_rate) - 8'd1;
    // '>=' so lowering RATE mid-ramp does not force a full 256-period wrap.
    assign w_match = (r_count >= w_limit);

    assign o_step_due = i_enable & i_period_start & w_match & ~i_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= 8'd0;
        else if (i_clear || o_step_due)
            r_count <= 8'd0;
        else if (i_enable && i_period_start)
            r_count <= r_count + 8'd1;
    end

endmodule
`default_nettype wire

// File: rtl/tqvp_pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tqvp_pwm_fade_ctrl
// Brief    : Register-mapped PWM duty fader with one-shot and breathe modes.
// Revision : 1.0 - initial release
// ============================================================================
module tqvp_pwm_fade_ctrl
    import pwm_fade_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       period_start,
    output logic [7:0] duty_out,
    output logic       busy,
    output logic       done_irq
);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [7:0] r_target;
    logic [7:0] r_step;
    logic [7:0] r_rate;
    logic [1:0] r_ctrl;
    logic [7:0] r_duty;
    logic       r_done_sticky;
    logic       r_done_irq;
    logic       r_goal_zero;
    logic       w_busy;

    logic       w_wr_target;
    logic       w_wr_ctrl;
    logic       w_restart;
    logic       w_hold_same;
    logic       w_step_due;
    logic       w_reached;
    logic [7:0] w_goal;
    logic [7:0] w_next_duty;

    assign w_wr_target = data_write && (address == c_ADDR_TARGET);
    assign w_wr_ctrl   = data_write && (address == c_ADDR_CTRL);
    assign w_restart   = w_wr_target && r_ctrl[c_CTRL_EN];
    assign w_hold_same = (r_state == c_ST_HOLD) && (data_in == r_duty);
    assign w_goal      = r_goal_zero ? 8'd0 : r_target;
    assign w_next_duty = f_step_toward(r_duty, f_at_least_one(r_step), w_goal);
    assign w_reached   = (w_next_duty == w_goal);

    // Any restarting write clears the prescaler, which also suppresses a coincident step.
    pwm_fade_tick u_tick (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_enable       (r_state == c_ST_RAMP),
        .i_clear        (w_wr_ctrl || w_restart),
        .i_period_start (period_start),
        .i_rate         (r_rate),
        .o_step_due     (w_step_due)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (w_wr_ctrl)
            w_next_state = data_in[c_CTRL_EN] ? c_ST_RAMP : c_ST_IDLE;
        else if (w_restart)
            w_next_state = w_hold_same ? c_ST_HOLD : c_ST_RAMP;
        else if ((r_state == c_ST_RAMP) && w_step_due && w_reached && !r_ctrl[c_CTRL_BREATHE])
            w_next_state = c_ST_HOLD;
    end

    always_comb begin
        w_busy = (r_state == c_ST_RAMP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target      <= 8'd0;
            r_step        <= 8'd0;
            r_rate        <= 8'd0;
            r_ctrl        <= 2'd0;
            r_duty        <= 8'd0;
            r_done_sticky <= 1'b0;
            r_done_irq    <= 1'b0;
            r_goal_zero   <= 1'b0;
        end else begin
            r_done_irq <= 1'b0;
            if (data_write) begin
                case (address)
                    c_ADDR_TARGET: r_target <= data_in;
                    c_ADDR_STEP:   r_step   <= data_in;
                    c_ADDR_RATE:   r_rate   <= data_in;
                    c_ADDR_CTRL:   r_ctrl   <= data_in[1:0];
                    default:       ;
                endcase
            end
            if (w_wr_ctrl) begin
                r_done_sticky <= 1'b0;
                r_goal_zero   <= 1'b0;
            end else if (w_restart) begin
                r_goal_zero <= 1'b0;
                if (w_hold_same) begin
                    r_done_irq    <= 1'b1;
                    r_done_sticky <= 1'b1;
                end
            end else if ((r_state == c_ST_RAMP) && w_step_due) begin
                r_duty <= w_next_duty;
                if (w_reached) begin
                    // In breathe mode only arrival at TARGET counts as completion.
                    if (!r_ctrl[c_CTRL_BREATHE] || !r_goal_zero) begin
                        r_done_irq    <= 1'b1;
                        r_done_sticky <= 1'b1;
                    end
                    if (r_ctrl[c_CTRL_BREATHE])
                        r_goal_zero <= ~r_goal_zero;
                end
            end
        end
    end

    always_comb begin
        data_out = 8'h00;
        case (address)
            c_ADDR_TARGET: data_out = r_target;
            c_ADDR_STEP:   data_out = r_step;
            c_ADDR_RATE:   data_out = r_rate;
            c_ADDR_CTRL:   data_out = {6'b0, r_ctrl};
            c_ADDR_STATUS: data_out = {6'b0, r_done_sticky, w_busy};
            c_ADDR_DUTY:   data_out = r_duty;
            default:       data_out = 8'h00;
        endcase
    end

    assign duty_out = r_duty;
    assign busy     = w_busy;
    assign done_irq = r_done_irq;

endmodule
`default_nettype wire

// File: tb/tb_tqvp_pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tqvp_pwm_fade_ctrl
// Brief    : Directed, table-driven self-checking bench for the PWM fader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tqvp_pwm_fade_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       period_start;
    logic [7:0] duty_out;
    logic       busy;
    logic       done_irq;

    int n_checks;
    int n_errors;

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } reg_vec_t;

    reg_vec_t vecs [10];

    tqvp_pwm_fade_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address      (address),
        .data_write   (data_write),
        .data_in      (data_in),
        .data_out     (data_out),
        .period_start (period_start),
        .duty_out     (duty_out),
        .busy         (busy),
        .done_irq     (done_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; address = 4'h0; data_write = 1'b0; data_in = 8'h00; period_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a; data_in = d; data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
    endtask

    // One PWM period compressed to a few clocks; ends one cycle after the wrap pulse.
    task automatic period();
        @(negedge clk);
        period_start = 1'b1;
        @(negedge clk);
        period_start = 1'b0;
    endtask

    task automatic rd(input string name, input logic [3:0] a, input int exp);
        address = a; data_write = 1'b0;
        #1;
        chk(name, int'(data_out), exp);
    endtask

    initial begin
        int exp_b [8];
        int exp_c [4];
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; address = 4'h0; data_write = 1'b0; data_in = 8'h00; period_start = 1'b0;

        vecs[0] = '{1'b0, 4'h0, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 4'h1, 8'h5A, 8'h5A};
        vecs[2] = '{1'b1, 4'h2, 8'h07, 8'h07};
        vecs[3] = '{1'b1, 4'h0, 8'h33, 8'h33};
        vecs[4] = '{1'b1, 4'h3, 8'h02, 8'h02};
        vecs[5] = '{1'b1, 4'h4, 8'hFF, 8'h00};
        vecs[6] = '{1'b1, 4'h5, 8'hAA, 8'h00};
        vecs[7] = '{1'b1, 4'h9, 8'h11, 8'h00};
        vecs[8] = '{1'b0, 4'hF, 8'h00, 8'h00};
        vecs[9] = '{1'b0, 4'h1, 8'h00, 8'h5A};

        // Reset state
        do_reset();
        chk("reset_duty", int'(duty_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done_irq), 0);
        rd("reset_rd_target", 4'h0, 0);

        // Register map table
        foreach (vecs[i]) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data);
            rd($sformatf("regvec%0d", i), vecs[i].addr, int'(vecs[i].exp));
        end
        chk("regvec_no_ramp", int'(busy), 0);

        // Linear ramp 0 -> 100 by 10
        do_reset();
        wr(4'h0, 8'd100); wr(4'h1, 8'd10); wr(4'h2, 8'd1); wr(4'h3, 8'h01);
        chk("ramp_busy_start", int'(busy), 1);
        for (int i = 1; i <= 10; i++) begin
            period();
            chk($sformatf("ramp_duty_%0d", i), int'(duty_out), 10 * i);
            chk($sformatf("ramp_done_%0d", i), int'(done_irq), (i == 10) ? 1 : 0);
        end
        @(negedge clk);
        chk("ramp_done_single", int'(done_irq), 0);
        chk("ramp_busy_end", int'(busy), 0);
        rd("status_after_ramp", 4'h4, 2);
        @(negedge clk);
        rd("status_reread", 4'h4, 2);
        period();
        chk("hold_duty_stays", int'(duty_out), 100);
        wr(4'h3, 8'h00);
        rd("status_ctrl_clears", 4'h4, 0);

        // Clamp at 255, RATE=2
        do_reset();
        wr(4'h0, 8'd255); wr(4'h1, 8'd200); wr(4'h2, 8'd2); wr(4'h3, 8'h01);
        exp_c = '{0, 200, 200, 255};
        for (int i = 0; i < 4; i++) begin
            period();
            chk($sformatf("clamp_duty_%0d", i + 1), int'(duty_out), exp_c[i]);
        end
        chk("clamp_busy_end", int'(busy), 0);

        // Breathe
        do_reset();
        wr(4'h0, 8'd30); wr(4'h1, 8'd15); wr(4'h2, 8'd1); wr(4'h3, 8'h03);
        exp_b = '{15, 30, 15, 0, 15, 30, 15, 0};
        for (int i = 0; i < 8; i++) begin
            period();
            chk($sformatf("breathe_duty_%0d", i + 1), int'(duty_out), exp_b[i]);
            chk($sformatf("breathe_done_%0d", i + 1), int'(done_irq), (exp_b[i] == 30) ? 1 : 0);
        end
        chk("breathe_busy", int'(busy), 1);

        // Disable mid-ramp freezes duty
        do_reset();
        wr(4'h0, 8'd100); wr(4'h1, 8'd10); wr(4'h2, 8'd1); wr(4'h3, 8'h01);
        for (int i = 0; i < 4; i++) period();
        chk("freeze_pre", int'(duty_out), 40);
        wr(4'h3, 8'h00);
        chk("freeze_busy", int'(busy), 0);
        for (int i = 0; i < 5; i++) begin
            period();
            chk($sformatf("freeze_duty_%0d", i + 1), int'(duty_out), 40);
        end
        rd("freeze_rd_duty", 4'h5, 40);
        rd("freeze_status", 4'h4, 0);

        // TARGET write coincident with a step-due period_start
        do_reset();
        wr(4'h0, 8'd100); wr(4'h1, 8'd10); wr(4'h2, 8'd1); wr(4'h3, 8'h01);
        period(); period();
        @(negedge clk);
        address = 4'h0; data_in = 8'd50; data_write = 1'b1; period_start = 1'b1;
        @(negedge clk);
        data_write = 1'b0; period_start = 1'b0;
        chk("coinc_no_step", int'(duty_out), 20);
        chk("coinc_busy", int'(busy), 1);
        for (int i = 3; i <= 5; i++) begin
            period();
            chk($sformatf("coinc_duty_%0d", i), int'(duty_out), 10 * i);
        end
        chk("coinc_done", int'(done_irq), 1);
        chk("coinc_hold", int'(busy), 0);
        // HOLD: equal target pulses done without moving, lower target ramps down
        wr(4'h0, 8'd50);
        chk("hold_eq_done", int'(done_irq), 1);
        chk("hold_eq_duty", int'(duty_out), 50);
        chk("hold_eq_busy", int'(busy), 0);
        wr(4'h0, 8'd30);
        chk("hold_down_busy", int'(busy), 1);
        period();
        chk("down_duty_1", int'(duty_out), 40);
        period();
        chk("down_duty_2", int'(duty_out), 30);
        chk("down_done", int'(done_irq), 1);

        // STEP=0 and RATE=0 behave as 1
        do_reset();
        wr(4'h0, 8'd3); wr(4'h3, 8'h01);
        for (int i = 1; i <= 3; i++) begin
            period();
            chk($sformatf("zero_cfg_duty_%0d", i), int'(duty_out), i);
        end
        chk("zero_cfg_hold", int'(busy), 0);

        // Async reset mid-ramp
        do_reset();
        wr(4'h0, 8'd100); wr(4'h1, 8'd10); wr(4'h2, 8'd1); wr(4'h3, 8'h01);
        period(); period(); period();
        chk("areset_pre", int'(duty_out), 30);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_duty", int'(duty_out), 0);
        chk("areset_busy", int'(busy), 0);
        rd("areset_target", 4'h0, 0);
        rd("areset_step", 4'h1, 0);
        rd("areset_ctrl", 4'h3, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            period();
            chk($sformatf("areset_post_done_%0d", i), int'(done_irq), 0);
            chk($sformatf("areset_post_duty_%0d", i), int'(duty_out), 0);
        end
        chk("areset_post_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
